// File: rtl/nibble_serial_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Holds the FSM state encoding and the nibble width.
package nibble_serial_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_cla4_core.sv
// 4-bit carry-lookahead adder core, purely combinational.
// Each carry is formed only from the generate/propagate terms of lower bits.
module cla4_core (
  input  logic [3:0] a4,
  input  logic [3:0] b4,
  input  logic       ci,
  output logic [3:0] s4,
  output logic       co
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  assign p = a4 ^ b4;
  assign g = a4 & b4;

  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s4 = p ^ c;

endmodule

// File: rtl/nibble_serial_adder.sv
// Serial WIDTH-bit adder that processes one nibble per cycle, LSB nibble first.
// Optional signed-overflow output enabled by NIBBLE_SERIAL_ADDER_OVF_EN.
module nibble_serial_adder
  import nibble_serial_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = $clog2(NIBBLES) + 1;

  state_t               state;
  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH-1:0]     b_reg;
  logic [WIDTH-1:0]     part;
  logic [WIDTH-1:0]     next_part;
  logic [IDX_W-1:0]     idx;
  logic                 carry;
  logic [NIBBLE_W-1:0]  a_nib;
  logic [NIBBLE_W-1:0]  b_nib;
  logic [NIBBLE_W-1:0]  s4;
  logic                 co;
  logic                 last;

  // Select the active nibble pair and merge the core result into the partial sum.
  always_comb begin
    a_nib     = '0;
    b_nib     = '0;
    next_part = part;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IDX_W'(i)) begin
        a_nib = a_reg[i*NIBBLE_W +: NIBBLE_W];
        b_nib = b_reg[i*NIBBLE_W +: NIBBLE_W];
        next_part[i*NIBBLE_W +: NIBBLE_W] = s4;
      end
    end
  end

  assign last = (idx == IDX_W'(NIBBLES - 1));

  cla4_core u_cla4 (
    .a4 (a_nib),
    .b4 (b_nib),
    .ci (carry),
    .s4 (s4),
    .co (co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      part  <= '0;
      idx   <= '0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          part  <= next_part;
          carry <= co;
          idx   <= idx + IDX_W'(1);
          if (last) begin
            sum   <= next_part;
            cout  <= co;
            done  <= 1'b1;
            state <= DONE;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            // Carry into the MSB is recovered from the MSB sum bit and its operands.
            ovf   <= (a_nib[NIBBLE_W-1] ^ b_nib[NIBBLE_W-1] ^ s4[NIBBLE_W-1]) ^ co;
`endif
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
